oled_mode_scheduler: RTL and testbench

Sequencer and arbiter that sits directly above `OLED_interface` and shares its single `i_MODE`/`i_START`/`o_READY` command port between several requesters, such as a power manager and a graphics engine. It picks one pending request round-robin, runs the start/ready handshake with the OLED interface, tracks whether the display is powered, and reports grant, done and error per requester. A start-acceptance timeout guards against a hung interface.

---
 rtl/oled_mode_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_oled_mode_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_mode_scheduler.sv
// Round-robin arbiter and start/ready sequencer in front of OLED_interface.
// Optional build macro OLED_AUTO_POWERON_EN inserts a power-on before write/clear while the display is off.
module oled_mode_scheduler #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic [NREQ-1:0]   i_REQ,
  input  logic [2*NREQ-1:0] i_REQ_MODE,
  output logic [NREQ-1:0]   o_GNT,
  output logic [NREQ-1:0]   o_DONE,
  output logic [NREQ-1:0]   o_ERR,
  output logic [1:0]        o_OLED_MODE,
  output logic              o_OLED_START,
  input  logic              i_OLED_READY,
  output logic              o_PWR_ON,
  output logic              o_BUSY
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TO_VAL   = CW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef OLED_AUTO_POWERON_EN
    S_PWRUP = 3'd1,
`endif
    S_ISSUE = 3'd2,
    S_BUSY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [1:0]        mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [1:0]        oled_mode_q, oled_mode_d;
  logic              start_q, start_d;
  logic              pwr_on_q, pwr_on_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [IW-1:0]     win;
  logic [IW-1:0]     cand;
  logic [1:0]        win_mode;

  // Search begins one past the last granted requester and wraps.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_q) + i) % NREQ);
      if (!found && i_REQ[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_mode = i_REQ_MODE[{win, 1'b0} +: 2];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = '0;
    oled_mode_d = oled_mode_q;
    start_d     = start_q;
    pwr_on_d    = pwr_on_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (i_OLED_READY && found) begin
          idx_d  = win;
          last_d = win;
          mode_d = win_mode;
          gnt_d  = ONE << win;
          busy_d = 1'b1;
          cnt_d  = '0;
          if (win_mode[1] && !pwr_on_q) begin
`ifdef OLED_AUTO_POWERON_EN
            state_d     = S_PWRUP;
            start_d     = 1'b1;
            oled_mode_d = 2'b00;
`else
            state_d = S_DONE;
            err_d   = ONE << win;
`endif
          end else begin
            state_d     = S_ISSUE;
            start_d     = 1'b1;
            oled_mode_d = win_mode;
          end
        end
      end

`ifdef OLED_AUTO_POWERON_EN
      // start_q high marks the accept phase of the inserted power-on, low the busy phase.
      S_PWRUP: begin
        if (start_q) begin
          if (!i_OLED_READY) begin
            start_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == TO_VAL) begin
              start_d = 1'b0;
              state_d = S_DONE;
              err_d   = ONE << idx_q;
            end
          end
        end else if (i_OLED_READY) begin
          pwr_on_d    = 1'b1;
          state_d     = S_ISSUE;
          start_d     = 1'b1;
          oled_mode_d = mode_q;
          cnt_d       = '0;
        end
      end
`endif

      S_ISSUE: begin
        if (!i_OLED_READY) begin
          start_d = 1'b0;
          state_d = S_BUSY;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TO_VAL) begin
            start_d = 1'b0;
            state_d = S_DONE;
            err_d   = ONE << idx_q;
          end
        end
      end

      S_BUSY: begin
        if (i_OLED_READY) begin
          state_d = S_DONE;
          done_d  = ONE << idx_q;
          if (mode_q == 2'b00) pwr_on_d = 1'b1;
          if (mode_q == 2'b01) pwr_on_d = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= LAST_RST;
      mode_q      <= 2'b00;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      oled_mode_q <= 2'b00;
      start_q     <= 1'b0;
      pwr_on_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      oled_mode_q <= oled_mode_d;
      start_q     <= start_d;
      pwr_on_q    <= pwr_on_d;
      busy_q      <= busy_d;
    end
  end

  assign o_GNT        = gnt_q;
  assign o_DONE       = done_q;
  assign o_ERR        = err_q;
  assign o_OLED_MODE  = oled_mode_q;
  assign o_OLED_START = start_q;
  assign o_PWR_ON     = pwr_on_q;
  assign o_BUSY       = busy_q;

endmodule

// File: tb/tb_oled_mode_scheduler.sv
// Scoreboard bench for oled_mode_scheduler: a transaction-level model predicts grants,
// issued commands and completions; a monitor compares them as the DUT presents them.
module tb_oled_mode_scheduler;
  localparam int NREQ = 2;
  localparam int TO   = 8;

  logic              i_CLK, i_RST;
  logic [NREQ-1:0]   i_REQ;
  logic [2*NREQ-1:0] i_REQ_MODE;
  logic [NREQ-1:0]   o_GNT, o_DONE, o_ERR;
  logic [1:0]        o_OLED_MODE;
  logic              o_OLED_START, i_OLED_READY, o_PWR_ON, o_BUSY;

  oled_mode_scheduler #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_REQ(i_REQ), .i_REQ_MODE(i_REQ_MODE),
    .o_GNT(o_GNT), .o_DONE(o_DONE), .o_ERR(o_ERR), .o_OLED_MODE(o_OLED_MODE),
    .o_OLED_START(o_OLED_START), .i_OLED_READY(i_OLED_READY),
    .o_PWR_ON(o_PWR_ON), .o_BUSY(o_BUSY)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  typedef struct { logic [1:0] mode; int dur; } issue_t;
  typedef struct { logic [NREQ-1:0] done; logic [NREQ-1:0] err; logic pwr; } cpl_t;

  logic [NREQ-1:0] exp_gnt[$];
  issue_t          exp_iss[$];
  cpl_t            exp_cpl[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: power state and round-robin pointer at transaction level.
  bit m_pwr;
  int m_last;

  task automatic predict(input logic [NREQ-1:0] mask, input logic [2*NREQ-1:0] modes,
                         input int acc, input bit stuck);
    int w;
    logic [1:0] m;
    logic [NREQ-1:0] oh;
    issue_t is;
    cpl_t c;
    w = m_last;
    for (int s = 1; s <= NREQ; s++) begin
      int r;
      r = (m_last + s) % NREQ;
      if (mask[r]) begin w = r; break; end
    end
    m_last = w;
    m = modes[2*w +: 2];
    oh = '0;
    oh[w] = 1'b1;
    exp_gnt.push_back(oh);
    is.dur = stuck ? TO : acc;
    c.done = '0;
    c.err  = '0;
    if (m[1] && !m_pwr) begin
`ifdef OLED_AUTO_POWERON_EN
      is.mode = 2'b00;
      exp_iss.push_back(is);
      if (stuck) begin
        c.err = oh; c.pwr = m_pwr; exp_cpl.push_back(c);
        return;
      end
      m_pwr = 1'b1;
`else
      c.err = oh; c.pwr = m_pwr; exp_cpl.push_back(c);
      return;
`endif
    end
    is.mode = m;
    exp_iss.push_back(is);
    if (stuck) begin
      c.err = oh;
    end else begin
      if (m == 2'b00) m_pwr = 1'b1;
      if (m == 2'b01) m_pwr = 1'b0;
      c.done = oh;
    end
    c.pwr = m_pwr;
    exp_cpl.push_back(c);
  endtask

  // OLED_interface stand-in: drops ready acc_cfg cycles into a start, holds it low bsy_cfg cycles.
  int acc_cfg = 2, bsy_cfg = 10;
  bit stuck_cfg = 1'b0;
  int rm_hold = 0;

  initial begin
    int seen;
    seen = 0;
    i_OLED_READY = 1'b1;
    forever begin
      @(negedge i_CLK);
      if (rm_hold > 0) begin
        rm_hold--;
        if (rm_hold == 0) i_OLED_READY = 1'b1;
      end else if (o_OLED_START) begin
        seen++;
        if (!stuck_cfg && seen == acc_cfg) begin
          i_OLED_READY = 1'b0;
          rm_hold = bsy_cfg;
          seen = 0;
        end
      end else begin
        seen = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant, a start or a completion.
  initial begin
    bit prev_start;
    int hi_cnt;
    int exp_dur;
    prev_start = 1'b0;
    hi_cnt = 0;
    exp_dur = 0;
    forever begin
      @(negedge i_CLK);
      if (i_RST) begin
        prev_start = 1'b0;
        hi_cnt = 0;
      end else begin
        if (o_GNT != '0) begin
          if (exp_gnt.size() == 0) chk("unexpected_gnt", o_GNT, 0);
          else begin
            chk("gnt", o_GNT, exp_gnt.pop_front());
            chk("busy_at_gnt", o_BUSY, 1);
          end
        end
        if (o_OLED_START && !prev_start) begin
          if (exp_iss.size() == 0) chk("unexpected_start", o_OLED_START, 0);
          else begin
            issue_t e;
            e = exp_iss.pop_front();
            chk("issue_mode", o_OLED_MODE, e.mode);
            exp_dur = e.dur;
          end
          hi_cnt = 0;
        end
        if (o_OLED_START) hi_cnt++;
        if (!o_OLED_START && prev_start) chk("start_high_cycles", hi_cnt, exp_dur);
        prev_start = o_OLED_START;
        if ((o_DONE | o_ERR) != '0) begin
          if (exp_cpl.size() == 0) chk("unexpected_completion", {o_DONE, o_ERR}, 0);
          else begin
            cpl_t c;
            c = exp_cpl.pop_front();
            chk("done", o_DONE, c.done);
            chk("err", o_ERR, c.err);
            chk("pwr_at_completion", o_PWR_ON, c.pwr);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int b;
    b = 0;
    while ((o_BUSY || rm_hold != 0) && b < 200) begin
      @(negedge i_CLK);
      b++;
    end
    chk("idle_wait_expired", (o_BUSY || rm_hold != 0), 0);
  endtask

  // Request mask held for n grants, then dropped right after the n-th grant.
  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [2*NREQ-1:0] modes,
                         input int acc, input int bsy, input bit stuck, input int n);
    int gots, cpls, b;
    acc_cfg = acc;
    bsy_cfg = bsy;
    stuck_cfg = stuck;
    for (int i = 0; i < n; i++) predict(mask, modes, acc, stuck);
    @(negedge i_CLK);
    i_REQ = mask;
    i_REQ_MODE = modes;
    gots = 0; cpls = 0; b = 0;
    while (cpls < n && b < 600) begin
      @(negedge i_CLK);
      b++;
      if (o_GNT != '0) begin
        gots++;
        if (gots == n) i_REQ = '0;
      end
      if ((o_DONE | o_ERR) != '0) cpls++;
    end
    i_REQ = '0;
    chk("completion_count", cpls, n);
    wait_idle();
  endtask

  initial begin
    int b;
    #500000;
    $display("FAIL watchdog_expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    i_RST = 1'b1;
    i_REQ = '0;
    i_REQ_MODE = '0;
    m_pwr = 1'b0;
    m_last = NREQ - 1;
    repeat (3) @(negedge i_CLK);
    chk("rst_gnt", o_GNT, 0);
    chk("rst_done", o_DONE, 0);
    chk("rst_err", o_ERR, 0);
    chk("rst_start", o_OLED_START, 0);
    chk("rst_pwr", o_PWR_ON, 0);
    chk("rst_busy", o_BUSY, 0);
    chk("rst_mode", o_OLED_MODE, 0);
    i_RST = 1'b0;

    run_txn(2'b01, 4'b0000, 2, 10, 1'b0, 1);
    chk("pwr_after_on", o_PWR_ON, m_pwr);
    run_txn(2'b10, 4'b1010, 3, 2, 1'b0, 1);
    run_txn(2'b11, 4'b1010, 2, 3, 1'b0, 3);
    run_txn(2'b01, 4'b0101, 1, 4, 1'b0, 1);
    chk("pwr_after_off", o_PWR_ON, m_pwr);
    run_txn(2'b10, 4'b1100, 2, 5, 1'b0, 1);
    chk("pwr_after_autoclear", o_PWR_ON, m_pwr);
    run_txn(2'b11, 4'b0101, 2, 2, 1'b1, 1);
    chk("pwr_after_timeout", o_PWR_ON, m_pwr);
    run_txn(2'b01, 4'b0000, 8, 3, 1'b0, 1);
    run_txn(2'b10, 4'b1000, 1, 1, 1'b1, 1);
    chk("pwr_kept_on_timeout", o_PWR_ON, m_pwr);

    // Reset while BUSY: no completion may appear and arbitration restarts at requester 0.
    acc_cfg = 1; bsy_cfg = 20; stuck_cfg = 1'b0;
    predict(2'b01, 4'b0101, 1, 1'b0);
    @(negedge i_CLK);
    i_REQ = 2'b01; i_REQ_MODE = 4'b0101;
    b = 0;
    while (o_GNT == '0 && b < 50) begin @(negedge i_CLK); b++; end
    i_REQ = '0;
    @(negedge i_CLK);
    b = 0;
    while (o_OLED_START && b < 50) begin @(negedge i_CLK); b++; end
    chk("reached_busy", o_OLED_START, 0);
    i_RST = 1'b1;
    @(negedge i_CLK);
    chk("midrst_gnt", o_GNT, 0);
    chk("midrst_done", o_DONE, 0);
    chk("midrst_err", o_ERR, 0);
    chk("midrst_start", o_OLED_START, 0);
    chk("midrst_pwr", o_PWR_ON, 0);
    chk("midrst_busy", o_BUSY, 0);
    chk("midrst_mode", o_OLED_MODE, 0);
    i_RST = 1'b0;
    exp_cpl.delete();
    m_pwr = 1'b0;
    m_last = NREQ - 1;
    wait_idle();
    run_txn(2'b11, 4'b0000, 2, 2, 1'b0, 1);

    for (int t = 0; t < 30; t++) begin
      logic [NREQ-1:0] mk;
      logic [2*NREQ-1:0] md;
      mk = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      md = (2*NREQ)'($urandom);
      run_txn(mk, md, $urandom_range(1, 8), $urandom_range(1, 12),
              ($urandom_range(0, 7) == 0), $urandom_range(1, 3));
    end

    repeat (5) @(negedge i_CLK);
    chk("gnt_queue_empty", exp_gnt.size(), 0);
    chk("issue_queue_empty", exp_iss.size(), 0);
    chk("cpl_queue_empty", exp_cpl.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
